checksum_scheduler: RTL and testbench

Round-robin scheduler that shares one `checksum_calculator` instance among `C_NUM_REQ` frame-building requesters in the latency measurer. It accepts one job at a time, resets and triggers the engine with the winner's words, then returns the 16-bit ones'-complement checksum to that requester with a one-cycle response pulse. The engine is one-shot after its reset, so this block must reset it before every job.

---
 rtl/checksum_scheduler.sv | 151 +++++++++++++++
 tb/tb_checksum_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checksum_scheduler.sv
// checksum_scheduler
//
// Shares one one-shot checksum engine among C_NUM_REQ requesters. Jobs are
// granted round-robin one at a time. Each job resets the engine, triggers it
// with the winner's words, waits for the result and returns it to the owner
// with a one-cycle response pulse.
//
// Handshake: a job transfers on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. req_valid and that requester's req_values slice
// must stay stable until then; dropping req_valid earlier withdraws the job.
// req_ready is one-hot, combinational, and only ever high in IDLE.
// resp_valid is a registered one-hot pulse of exactly one cycle, with
// resp_checksum valid in that cycle and held until the next capture.
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   req_valid      : per-requester job request
//   req_values     : requester i at [i*16*C_NUM_VALUES +: 16*C_NUM_VALUES], word 0 in LSBs
//   req_ready      : one-hot grant (IDLE only)
//   resp_valid     : one-hot response pulse to the job owner
//   resp_checksum  : 16-bit ones'-complement checksum of the last job
//   busy           : a job is in flight (state != IDLE)
//   cs_rst         : active-high engine reset
//   cs_trigger     : engine start pulse
//   cs_values      : job words presented to the engine
//   cs_checksum    : engine result
module checksum_scheduler #(
    parameter int C_NUM_REQ    = 2,
    parameter int C_NUM_VALUES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [C_NUM_REQ-1:0]                  req_valid,
    input  logic [16*C_NUM_VALUES*C_NUM_REQ-1:0]  req_values,
    output logic [C_NUM_REQ-1:0]                  req_ready,
    output logic [C_NUM_REQ-1:0]                  resp_valid,
    output logic [15:0]                           resp_checksum,
    output logic                                  busy,
    output logic                                  cs_rst,
    output logic                                  cs_trigger,
    output logic [16*C_NUM_VALUES-1:0]            cs_values,
    input  logic [15:0]                           cs_checksum
);

    localparam int JOB_W = 16 * C_NUM_VALUES;
    localparam int PTR_W = $clog2(C_NUM_REQ);
    localparam int CNT_W = $clog2(C_NUM_VALUES + 2);
    localparam logic [CNT_W-1:0]     WAIT_LAST = CNT_W'(C_NUM_VALUES);
    localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(C_NUM_REQ - 1);
    localparam logic [C_NUM_REQ-1:0] ONE_HOT0  = C_NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        TRIG  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic [CNT_W-1:0] wait_cnt;

    // Round-robin search: first requester at or above ptr, wrapping around.
    always_comb begin : arbiter
        int                 cand;
        logic [C_NUM_REQ-1:0] shifted;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        shifted   = '0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= C_NUM_REQ) begin
                cand = cand - C_NUM_REQ;
            end
            shifted = req_valid >> cand;
            if (!win_found && shifted[0]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    always_comb begin : grant_out
        req_ready = '0;
        if (state == IDLE && win_found) begin
            req_ready = ONE_HOT0 << win_idx;
        end
    end

    always_comb begin : next_state
        state_next = state;
        case (state)
            IDLE:    if (win_found) state_next = CLEAR;
            CLEAR:   state_next = TRIG;
            TRIG:    state_next = WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The engine is one-shot, so it is held in reset with the block and
    // pulsed again in CLEAR before every job.
    assign cs_rst = ~rst_n | (state == CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            grant_idx     <= '0;
            wait_cnt      <= '0;
            cs_values     <= '0;
            resp_checksum <= 16'h0000;
            resp_valid    <= '0;
            busy          <= 1'b0;
            cs_trigger    <= 1'b0;
        end else begin
            state      <= state_next;
            // Registered decodes of the upcoming state keep these glitch-free.
            busy       <= (state_next != IDLE);
            cs_trigger <= (state_next == TRIG);
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        cs_values <= req_values[int'(win_idx)*JOB_W +: JOB_W];
                        grant_idx <= win_idx;
                        ptr       <= (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
                    end
                end
                TRIG: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        resp_checksum <= cs_checksum;
                        resp_valid    <= ONE_HOT0 << grant_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_checksum_scheduler.sv
// Bench for checksum_scheduler: two instances (default 2x2 and 3 requesters
// x 4 words), each paired with a behavioural one-shot checksum engine.
module tb_checksum_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: defaults ----------------
    logic [1:0]  a_req_valid = '0;
    logic [63:0] a_req_values = '0;
    logic [1:0]  a_req_ready, a_resp_valid;
    logic [15:0] a_resp_checksum, a_cs_checksum;
    logic        a_busy, a_cs_rst, a_cs_trigger;
    logic [31:0] a_cs_values;

    checksum_scheduler dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_values(a_req_values),
        .req_ready(a_req_ready), .resp_valid(a_resp_valid), .resp_checksum(a_resp_checksum),
        .busy(a_busy), .cs_rst(a_cs_rst), .cs_trigger(a_cs_trigger),
        .cs_values(a_cs_values), .cs_checksum(a_cs_checksum)
    );

    // ---------------- instance B: 3 requesters, 4 words ----------------
    logic [2:0]   b_req_valid = '0;
    logic [191:0] b_req_values = '0;
    logic [2:0]   b_req_ready, b_resp_valid;
    logic [15:0]  b_resp_checksum, b_cs_checksum;
    logic         b_busy, b_cs_rst, b_cs_trigger;
    logic [63:0]  b_cs_values;

    checksum_scheduler #(.C_NUM_REQ(3), .C_NUM_VALUES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_values(b_req_values),
        .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_checksum(b_resp_checksum),
        .busy(b_busy), .cs_rst(b_cs_rst), .cs_trigger(b_cs_trigger),
        .cs_values(b_cs_values), .cs_checksum(b_cs_checksum)
    );

    function automatic logic [15:0] csum(input logic [255:0] v, input int n);
        logic [16:0] s;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s = {1'b0, s[15:0]} + {1'b0, v[i*16 +: 16]};
            if (s[16]) s = {1'b0, s[15:0]} + 17'd1;
        end
        return (s[15:0] == 16'hFFFF) ? 16'hFFFF : ~s[15:0];
    endfunction

    // Engine models: one-shot after reset, result valid N edges after trigger.
    logic        a_armed = 1'b0, b_armed = 1'b0;
    int          a_cnt = 0, b_cnt = 0;
    logic [15:0] a_pend = '0, b_pend = '0;

    always @(posedge clk) begin
        if (a_cs_rst) begin
            a_armed <= 1'b1; a_cnt <= 0; a_cs_checksum <= 16'h0;
        end else if (a_cs_trigger && a_armed) begin
            a_armed <= 1'b0; a_cnt <= 2; a_pend <= csum(256'(a_cs_values), 2);
        end else if (a_cnt != 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) a_cs_checksum <= a_pend;
        end
    end

    always @(posedge clk) begin
        if (b_cs_rst) begin
            b_armed <= 1'b1; b_cnt <= 0; b_cs_checksum <= 16'h0;
        end else if (b_cs_trigger && b_armed) begin
            b_armed <= 1'b0; b_cnt <= 4; b_pend <= csum(256'(b_cs_values), 4);
        end else if (b_cnt != 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) b_cs_checksum <= b_pend;
        end
    end

    // Scoreboards: entry = {owner[1:0], checksum[15:0], due_cycle[31:0]}
    logic [49:0] a_exp_q[$];
    logic [49:0] b_exp_q[$];
    logic [49:0] a_ent, b_ent;

    always @(negedge clk) begin
        if (rst_n && a_resp_valid != 2'b00) begin
            vectors++;
            if (a_exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL a_resp_unexpected valid=%b cs=%h cyc=%0d", a_resp_valid, a_resp_checksum, cyc);
            end else begin
                a_ent = a_exp_q.pop_front();
                if (a_resp_valid !== (2'b01 << a_ent[49:48]) || a_resp_checksum !== a_ent[47:32] || cyc != int'(a_ent[31:0])) begin
                    miscompares++;
                    $display("FAIL a_resp got valid=%b cs=%h cyc=%0d expected valid=%b cs=%h cyc=%0d",
                             a_resp_valid, a_resp_checksum, cyc, 2'b01 << a_ent[49:48], a_ent[47:32], a_ent[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_resp_valid != 3'b000) begin
            vectors++;
            if (b_exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL b_resp_unexpected valid=%b cs=%h cyc=%0d", b_resp_valid, b_resp_checksum, cyc);
            end else begin
                b_ent = b_exp_q.pop_front();
                if (b_resp_valid !== (3'b001 << b_ent[49:48]) || b_resp_checksum !== b_ent[47:32] || cyc != int'(b_ent[31:0])) begin
                    miscompares++;
                    $display("FAIL b_resp got valid=%b cs=%h cyc=%0d expected valid=%b cs=%h cyc=%0d",
                             b_resp_valid, b_resp_checksum, cyc, 3'b001 << b_ent[49:48], b_ent[47:32], b_ent[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Raise a job on instance A and wait (bounded) for its accept; drops
    // req_valid on the following negedge.
    task automatic a_drive_job(input int idx, input logic [31:0] words, input logic [15:0] exp_cs,
                               output int acc_cyc, output logic ok);
        @(negedge clk);
        a_req_values[idx*32 +: 32] = words;
        a_req_valid[idx] = 1'b1;
        ok = 1'b0;
        acc_cyc = -1;
        for (int t = 0; t < 20 && !ok; t++) begin
            #1;
            if (a_req_ready[idx]) begin
                ok = 1'b1;
                acc_cyc = cyc;
                a_exp_q.push_back({2'(idx), exp_cs, 32'(cyc + 6)});
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        a_req_valid[idx] = 1'b0;
    endtask

    task automatic a_drain(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (a_exp_q.size() == 0) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic b_drain(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (b_exp_q.size() == 0) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk); #1;
        vectors++;
        if (a_cs_rst !== 1'b1 || b_cs_rst !== 1'b1 || a_busy !== 1'b0 || a_resp_valid !== 2'b00 ||
            a_cs_trigger !== 1'b0 || a_cs_values !== 32'h0 || a_resp_checksum !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_hold got cs_rst=%b/%b busy=%b rv=%b trig=%b vals=%h cs=%h expected 1/1 0 00 0 0 0",
                     a_cs_rst, b_cs_rst, a_busy, a_resp_valid, a_cs_trigger, a_cs_values, a_resp_checksum);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (a_cs_rst !== 1'b0 || a_req_ready !== 2'b00 || a_busy !== 1'b0 || b_busy !== 1'b0 || b_req_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release got cs_rst=%b ready=%b busy=%b/%b b_ready=%b expected 0 00 0/0 000",
                     a_cs_rst, a_req_ready, a_busy, b_busy, b_req_ready);
        end
    endtask

    task automatic test_single();
        int acc; logic ok;
        a_drive_job(0, {16'h5678, 16'h1234}, 16'h9753, acc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_accept got no grant expected req_ready[0]=1"); end
        #1; // cycle 1: CLEAR
        vectors++;
        if (a_busy !== 1'b1 || a_cs_rst !== 1'b1 || a_cs_trigger !== 1'b0) begin
            miscompares++;
            $display("FAIL single_clear got busy=%b cs_rst=%b trig=%b expected 1 1 0", a_busy, a_cs_rst, a_cs_trigger);
        end
        @(negedge clk); #1; // cycle 2: TRIG
        vectors++;
        if (a_cs_trigger !== 1'b1 || a_cs_rst !== 1'b0 || a_cs_values !== 32'h5678_1234) begin
            miscompares++;
            $display("FAIL single_trig got trig=%b cs_rst=%b vals=%h expected 1 0 56781234", a_cs_trigger, a_cs_rst, a_cs_values);
        end
        repeat (3) @(negedge clk); #1; // cycle 5: last WAIT
        vectors++;
        if (a_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_c5 got %b expected 1", a_busy); end
        @(negedge clk); #1; // cycle 6: response
        vectors++;
        if (a_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_c6 got %b expected 0", a_busy); end
        a_drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_timeout got pending=%0d expected 0", a_exp_q.size()); a_exp_q.delete(); end
    endtask

    task automatic test_carry();
        int acc; logic ok;
        a_drive_job(0, {16'h0001, 16'hFFFF}, 16'hFFFE, acc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL carry_accept got no grant expected grant"); end
        a_drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL carry_timeout got pending=%0d expected 0", a_exp_q.size()); a_exp_q.delete(); end
    endtask

    task automatic test_back_to_back();
        int acc; logic ok;
        logic [31:0] w [3];
        logic [15:0] r [3];
        w[0] = {16'hFFFF, 16'h0000}; r[0] = 16'hFFFF;
        w[1] = {16'h0000, 16'h0000}; r[1] = 16'hFFFF;
        w[2] = {16'h0002, 16'h0001}; r[2] = 16'hFFFC;
        for (int j = 0; j < 3; j++) begin
            a_drive_job(0, w[j], r[j], acc, ok);
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL b2b_accept job=%0d got no grant expected grant", j); end
        end
        a_drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_timeout got pending=%0d expected 0", a_exp_q.size()); a_exp_q.delete(); end
    endtask

    task automatic test_fairness();
        logic [31:0] w0, w1;
        logic found, ok;
        int prev;
        w0 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
        w1 = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
        a_req_values = {w1, w0};
        a_req_valid = 2'b11;
        apply_reset(2);
        prev = -1;
        for (int j = 0; j < 4; j++) begin
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                #1;
                if ((a_req_ready & a_req_valid) != 2'b00) found = 1'b1;
                else @(negedge clk);
            end
            vectors++;
            if (!found) begin
                miscompares++;
                $display("FAIL fair_timeout job=%0d got no grant expected grant", j);
            end else begin
                if (a_req_ready !== (2'b01 << (j % 2))) begin
                    miscompares++;
                    $display("FAIL fair_grant job=%0d got %b expected %b", j, a_req_ready, 2'b01 << (j % 2));
                end
                a_exp_q.push_back({2'(j % 2), (j % 2 == 0) ? csum(256'(w0), 2) : csum(256'(w1), 2), 32'(cyc + 6)});
                if (j > 0) begin
                    vectors++;
                    if (cyc - prev != 6) begin
                        miscompares++;
                        $display("FAIL fair_spacing job=%0d got %0d expected 6", j, cyc - prev);
                    end
                end
                prev = cyc;
                @(negedge clk);
            end
        end
        a_req_valid = 2'b00;
        a_drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL fair_drain got pending=%0d expected 0", a_exp_q.size()); a_exp_q.delete(); end
    endtask

    task automatic test_mid_reset();
        int acc; logic ok;
        logic [31:0] w;
        a_drive_job(0, {16'h1111, 16'h2222}, 16'hCCCC, acc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL midrst_accept got no grant expected grant"); end
        repeat (3) @(negedge clk); // cycle 4: WAIT
        rst_n = 1'b0;
        a_exp_q.delete();          // aborted job must produce no response
        w = {16'h00F0, 16'h0F00};
        a_req_values = {w, w};
        a_req_valid = 2'b11;
        @(negedge clk); #1;
        vectors++;
        if (a_busy !== 1'b0 || a_resp_valid !== 2'b00 || a_resp_checksum !== 16'h0 || a_cs_values !== 32'h0 ||
            a_cs_trigger !== 1'b0 || a_cs_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_outputs got busy=%b rv=%b cs=%h vals=%h trig=%b cs_rst=%b expected 0 00 0000 0 0 1",
                     a_busy, a_resp_valid, a_resp_checksum, a_cs_values, a_cs_trigger, a_cs_rst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (a_req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL midrst_first_grant got %b expected 01", a_req_ready);
        end
        a_exp_q.push_back({2'd0, csum(256'(w), 2), 32'(cyc + 6)});
        @(negedge clk);
        a_req_valid = 2'b00;
        a_drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL midrst_drain got pending=%0d expected 0", a_exp_q.size()); a_exp_q.delete(); end
    endtask

    task automatic test_withdrawal();
        logic ok;
        @(negedge clk);
        b_req_values[63:0] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        b_req_valid = 3'b001;
        #1;
        vectors++;
        if (b_req_ready !== 3'b001) begin miscompares++; $display("FAIL wd_grant got %b expected 001", b_req_ready); end
        b_exp_q.push_back({2'd0, 16'hFFF5, 32'(cyc + 8)});
        @(negedge clk);
        b_req_values[191:128] = 64'(32'($urandom));
        b_req_valid = 3'b100;      // requester 2 pulses while busy
        #1;
        vectors++;
        if (b_req_ready !== 3'b000 || b_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_busy_ready got ready=%b busy=%b expected 000 1", b_req_ready, b_busy);
        end
        @(negedge clk); #1;
        vectors++;
        if (b_req_ready !== 3'b000) begin miscompares++; $display("FAIL wd_busy_ready2 got %b expected 000", b_req_ready); end
        @(negedge clk);
        b_req_valid = 3'b000;      // withdrawn well before IDLE
        b_drain(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL wd_drain got pending=%0d expected 0", b_exp_q.size()); b_exp_q.delete(); end
        repeat (6) @(negedge clk); #1;
        vectors++;
        if (b_busy !== 1'b0 || b_resp_checksum !== 16'hFFF5) begin
            miscompares++;
            $display("FAIL wd_not_served got busy=%b cs=%h expected 0 fff5", b_busy, b_resp_checksum);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_back_to_back();
        test_fairness();
        test_mid_reset();
        test_withdrawal();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
